// File: rtl/e_mdu.sv
// Multiply/divide unit for the E stage: fixed-latency mult/multu/div/divu plus mthi/mtlo.
// Results come from operands captured at start and are committed to HI/LO on the edge that leaves RUN.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        state_dbg
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [CNT_W-1:0] cnt;

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        is_signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // One 64-bit multiplier serves both flavours: sign- or zero-extension
  // of the operands selects signed vs unsigned product.
  always_comb begin
    ext_a = {32'b0, a_q};
    ext_b = {32'b0, b_q};
    if (op_q == OP_MULT) begin
      ext_a = {{32{a_q[31]}}, a_q};
      ext_b = {{32{b_q[31]}}, b_q};
    end
    prod = ext_a * ext_b;
  end

  // Signed divide runs on magnitudes; this also makes 0x80000000 / -1
  // fall out as quotient 0x80000000, remainder 0 without a special case.
  always_comb begin
    is_signed_div = (op_q == OP_DIV);
    a_neg = is_signed_div & a_q[31];
    b_neg = is_signed_div & b_q[31];
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
          res_hi = a_neg ? (32'd0 - r_mag) : r_mag;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      cnt   <= '0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                op_q  <= op;
                a_q   <= A;
                b_q   <= B;
                cnt   <= MULT_LOAD;
                state <= RUN;
                busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                op_q  <= op;
                a_q   <= A;
                b_q   <= B;
                cnt   <= DIV_LOAD;
                state <= RUN;
                busy  <= 1'b1;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Any start seen here is dropped; operands and counter stay put.
          if (cnt == '0) begin
            HI    <= res_hi;
            LO    <= res_lo;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = (state == RUN);

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: each step drives a start, walks the busy window and
// checks HI/LO against hand-computed values.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        state_dbg;

  int checks;
  int failures;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .HI        (HI),
    .LO        (LO),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a start and follow the busy window; alt_a/alt_b are driven onto the
  // operand ports during RUN to prove the captured values are used.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] old_hi, input logic [31:0] old_lo);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
    A     = $urandom_range(0, 32'h7FFF_FFFF);
    B     = $urandom_range(1, 32'h7FFF_FFFF);
    check({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
    check({tag, "_dbg_run"}, {31'd0, state_dbg}, 32'd1);
    for (int i = 2; i <= cycles; i++) begin
      tick();
      check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
    end
    check({tag, "_hi_hold"}, HI, old_hi);
    check({tag, "_lo_hold"}, LO, old_lo);
    tick();
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    start    = 1'b0;
    op       = 3'd0;
    A        = 32'd0;
    B        = 32'd0;

    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // mult -2 * 3
    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'd0, 32'd0);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // multu back-to-back in the very next cycle
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);

    // signed min * min = 2^62
    run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    check("mult_min_hi", HI, 32'h4000_0000);
    check("mult_min_lo", LO, 32'h0000_0000);

    // div -7 / 2, with an mthi start attempted mid-run
    start = 1'b1; op = 3'd2; A = 32'hFFFF_FFF9; B = 32'd2;
    tick();
    start = 1'b1; op = 3'd4; A = 32'hDEAD_BEEF; B = 32'd0;
    tick();
    start = 1'b0;
    for (int i = 3; i <= 10; i++) tick();
    check("div_busy_last", {31'd0, busy}, 32'd1);
    check("div_hi_hold", HI, 32'h4000_0000);
    tick();
    check("div_busy_end", {31'd0, busy}, 32'd0);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // div 7 / -2
    run_op("div_nd", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    check("div_nd_lo", LO, 32'hFFFF_FFFD);
    check("div_nd_hi", HI, 32'h0000_0001);

    // div overflow case
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0000_0000);

    // signed divide by zero
    run_op("div_z", 3'd2, 32'hFFFF_FFFB, 32'd0, 10, 32'h0000_0000, 32'h8000_0000);
    check("div_z_lo", LO, 32'hFFFF_FFFF);
    check("div_z_hi", HI, 32'hFFFF_FFFB);

    // divu 0xFFFFFFFF / 16
    run_op("divu", 3'd3, 32'hFFFF_FFFF, 32'd16, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    check("divu_lo", LO, 32'h0FFF_FFFF);
    check("divu_hi", HI, 32'h0000_000F);

    // divu 100 / 0 with mtlo attempted during busy
    start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd0;
    tick();
    op = 3'd5; A = 32'd5;
    for (int i = 2; i <= 10; i++) tick();
    start = 1'b0;
    tick();
    check("divu_z_busy", {31'd0, busy}, 32'd0);
    check("divu_z_lo", LO, 32'hFFFF_FFFF);
    check("divu_z_hi", HI, 32'd100);

    // mthi: no busy, written on the edge
    start = 1'b1; op = 3'd4; A = 32'h1234_5678;
    tick();
    start = 1'b0;
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_lo", LO, 32'hFFFF_FFFF);

    // mtlo
    start = 1'b1; op = 3'd5; A = 32'hCAFE_0001;
    tick();
    start = 1'b0;
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_lo", LO, 32'hCAFE_0001);

    // reserved ops do nothing
    start = 1'b1; op = 3'd6; A = 32'h1111_1111; B = 32'h2222_2222;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    check("rsv_busy", {31'd0, busy}, 32'd0);
    check("rsv_hi", HI, 32'h1234_5678);
    check("rsv_lo", LO, 32'hCAFE_0001);

    // div aborted by reset pulse in busy cycle 4
    start = 1'b1; op = 3'd2; A = 32'd50; B = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("abort_busy_after", {31'd0, busy}, 32'd0);
    check("abort_hi_after", HI, 32'd0);
    check("abort_lo_after", LO, 32'd0);

    // first op after reset behaves from IDLE
    run_op("post_rst", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd0);
    check("post_rst_lo", LO, 32'd42);
    check("post_rst_hi", HI, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, is the number of busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, is the number of busy cycles for div/divu.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  E-stage instruction is a mult/multu/div/divu/mthi/mtlo; qualifies op.
REQ-006 op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved.
REQ-007 A  input  32  forwarded rs operand from E stage.
REQ-008 B  input  32  forwarded rt operand from E stage.
REQ-009 busy  output  1  operation in progress; hazard unit stalls D on busy|start for MDU instructions.
REQ-010 HI  output  32  HI register value.
REQ-011 LO  output  32  LO register value.

Function
REQ-012 States SHALL be IDLE and RUN; busy SHALL be 1 exactly in RUN.
REQ-013 start with op 0-3 in IDLE SHALL latch op, A, B and a cycle counter, and enter RUN on the same edge.
REQ-014 RUN SHALL last exactly MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3) cycles, counted from the cycle after the start edge.
REQ-015 HI/LO SHALL update on the edge that leaves RUN; busy SHALL fall on that edge.
REQ-016 HI/LO SHALL hold their old values throughout RUN.
REQ-017 mult: {HI,LO} SHALL equal the signed 64-bit product of A and B.
REQ-018 multu: {HI,LO} SHALL equal the unsigned 64-bit product.
REQ-019 div: LO SHALL be the signed quotient truncated toward zero; HI SHALL be the remainder, carrying the sign of the dividend.
REQ-020 divu: LO SHALL be the unsigned quotient; HI SHALL be the unsigned remainder.
REQ-021 Divide by zero (div/divu, B=0) SHALL give LO=0xFFFFFFFF and HI=A, using the same DIV_CYCLES latency.
REQ-022 div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-023 mthi/mtlo with start in IDLE SHALL write A to HI/LO on that edge, with no RUN and no busy.
REQ-024 start while busy=1 SHALL be ignored; it SHALL NOT disturb latched operands, the counter, or HI/LO.
REQ-025 Reserved op values with start SHALL be a no-op.
REQ-026 Operands SHALL be captured at start; changes on A/B during RUN SHALL NOT affect the result.
REQ-027 After leaving RUN the unit SHALL accept a new start in the very next cycle (back-to-back with one IDLE cycle minimum).
REQ-028 The implementation MAY be iterative or combinational-plus-delay; only the cycle timing at the ports is normative.

Reset
REQ-029 reset=0 SHALL immediately, independent of clk, force state IDLE, busy=0, HI=0, LO=0 and counter=0.
REQ-030 reset asserted during RUN SHALL abort the operation with no HI/LO update after release.
REQ-031 After reset is released, the first rising edge SHALL behave as IDLE.

Verification
REQ-032 mult, A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 div, A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 divu, A=100, B=0 -> after 10 cycles, LO=0xFFFFFFFF, HI=100; a mtlo start issued during busy leaves LO at 0xFFFFFFFF.
REQ-036 mthi, A=0x12345678 -> busy stays 0, and HI=0x12345678 on the next edge.
REQ-037 div started, reset=0 pulsed at busy cycle 4 between clock edges -> busy=0 and HI=LO=0 immediately, with no later update.
